// File: rtl/uart_csr_pkg.sv
// Shared constants and types for the UART CSR/FIFO block: register map,
// STAT bit positions, IRQ_EN bit positions and the CFG field layout.
package uart_csr_pkg;

  localparam int unsigned ADDR_TXDATA = 32'h00;
  localparam int unsigned ADDR_RXDATA = 32'h04;
  localparam int unsigned ADDR_CFG    = 32'h08;
  localparam int unsigned ADDR_CTRL   = 32'h0C;
  localparam int unsigned ADDR_STAT   = 32'h10;
  localparam int unsigned ADDR_IRQEN  = 32'h14;

  localparam int STAT_TX_EMPTY = 0;
  localparam int STAT_TX_FULL  = 1;
  localparam int STAT_RX_EMPTY = 2;
  localparam int STAT_RX_FULL  = 3;
  localparam int STAT_PERR     = 4;
  localparam int STAT_RX_OVF   = 5;
  localparam int STAT_TX_OVF   = 6;
  localparam int STAT_TX_LVL   = 8;
  localparam int STAT_RX_LVL   = 16;

  // IRQ_EN bit positions; bit 0 is the RX-non-empty source
  localparam int IRQ_RX_NONEMPTY = 0;
  localparam int IRQ_TX_EMPTY    = 1;
  localparam int IRQ_PERR        = 2;
  localparam int IRQ_OVF         = 3;

  typedef struct packed {
    logic       par_odd;
    logic       par_en;
    logic       stop;
    logic [1:0] data_bits;
  } cfg_t;

endpackage

// File: rtl/uart_csr_fifo_if.sv
// Register bus between the slave adapter and the UART CSR block:
// independent write and read channels, each with a one-cycle acknowledge.
interface uart_csr_fifo_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              wr_en;
  logic [ADDR_W-1:0] raddr;
  logic              rd_en;
  logic              wack;
  logic              waddrerr;
  logic              rack;
  logic              raddrerr;
  logic [DATA_W-1:0] rdata;

  modport master (
    output waddr, wdata, wr_en, raddr, rd_en,
    input  wack, waddrerr, rack, raddrerr, rdata
  );

  modport slave (
    input  waddr, wdata, wr_en, raddr, rd_en,
    output wack, waddrerr, rack, raddrerr, rdata
  );
endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers, combinational head output and a
// flush that overrides any push/pop issued in the same cycle.
module uart_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr_reg, wr_ptr_next;
  logic [AW:0]  rd_ptr_reg, rd_ptr_next;
  logic         do_push, do_pop;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign level = wr_ptr_reg - rd_ptr_reg;

  // A full FIFO refuses pushes even if it is being popped this cycle
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end else begin
      if (do_push) wr_ptr_next = wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= din;
  end

  assign dout = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/uart_csr_fifo.sv
// UART control/status register block: bus-mapped CFG/CTRL/STAT/IRQ_EN
// registers plus TX and RX FIFOs feeding/fed by the UART engines.
module uart_csr_fifo
  import uart_csr_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_csr_fifo_if.slave   bus,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic             rx_valid,
  input  logic [7:0]       rx_byte,
  input  logic             rx_perr,
  output logic [1:0]       cfg_data_bits,
  output logic             cfg_stop_bits,
  output logic             cfg_par_en,
  output logic             cfg_par_odd,
  output logic             irq
);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);

  cfg_t              cfg_reg, cfg_next;
  logic              tx_en_reg, tx_en_next;
  logic [3:0]        irq_en_reg, irq_en_next;
  logic [2:0]        sticky_reg, sticky_next;   // {tx_ovf, rx_ovf, perr}
  logic              wack_reg, waddrerr_reg, waddrerr_next;
  logic              rack_reg, raddrerr_reg, raddrerr_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic              irq_reg, irq_next;

  logic              wr_tx, wr_cfg, wr_ctrl, wr_stat, wr_irqen, rd_rx, flush;
  logic [2:0]        sticky_set, sticky_w1c;
  logic [3:0]        irq_src;
  logic [DATA_W-1:0] stat_word;

  logic              tx_empty, tx_full, tx_pop;
  logic              rx_empty, rx_full;
  logic [7:0]        rx_dout;
  logic [TX_AW:0]    tx_level;
  logic [RX_AW:0]    rx_level;
  logic              unused_wdata;

  assign unused_wdata = ^bus.wdata[DATA_W-1:8];

  // Full-address write decode; RXDATA is read-only and so falls to the error path
  always_comb begin
    wr_tx    = bus.wr_en && (bus.waddr == ADDR_W'(ADDR_TXDATA));
    wr_cfg   = bus.wr_en && (bus.waddr == ADDR_W'(ADDR_CFG));
    wr_ctrl  = bus.wr_en && (bus.waddr == ADDR_W'(ADDR_CTRL));
    wr_stat  = bus.wr_en && (bus.waddr == ADDR_W'(ADDR_STAT));
    wr_irqen = bus.wr_en && (bus.waddr == ADDR_W'(ADDR_IRQEN));
    waddrerr_next = bus.wr_en && !(wr_tx || wr_cfg || wr_ctrl || wr_stat || wr_irqen);
    flush    = wr_ctrl && bus.wdata[1];
  end

  assign tx_valid = !tx_empty && tx_en_reg;
  assign tx_pop   = tx_valid && tx_ready;

  uart_sync_fifo #(.W(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_tx),
    .pop   (tx_pop),
    .flush (flush),
    .din   (bus.wdata[7:0]),
    .dout  (tx_data),
    .empty (tx_empty),
    .full  (tx_full),
    .level (tx_level)
  );

  uart_sync_fifo #(.W(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_valid),
    .pop   (rd_rx),
    .flush (flush),
    .din   (rx_byte),
    .dout  (rx_dout),
    .empty (rx_empty),
    .full  (rx_full),
    .level (rx_level)
  );

  always_comb begin
    stat_word                = '0;
    stat_word[STAT_TX_EMPTY] = tx_empty;
    stat_word[STAT_TX_FULL]  = tx_full;
    stat_word[STAT_RX_EMPTY] = rx_empty;
    stat_word[STAT_RX_FULL]  = rx_full;
    stat_word[STAT_PERR]     = sticky_reg[0];
    stat_word[STAT_RX_OVF]   = sticky_reg[1];
    stat_word[STAT_TX_OVF]   = sticky_reg[2];
    stat_word[STAT_TX_LVL +: 8] = 8'(tx_level);
    stat_word[STAT_RX_LVL +: 8] = 8'(rx_level);
  end

  // Read path samples pre-edge state; an RXDATA read pops in the same cycle
  always_comb begin
    rdata_next    = rdata_reg;
    raddrerr_next = 1'b0;
    rd_rx         = 1'b0;
    if (bus.rd_en) begin
      rdata_next = '0;
      case (bus.raddr)
        ADDR_W'(ADDR_TXDATA): rdata_next = '0;
        ADDR_W'(ADDR_RXDATA): begin
          rd_rx = 1'b1;
          if (!rx_empty) rdata_next[7:0] = rx_dout;
        end
        ADDR_W'(ADDR_CFG):    rdata_next[4:0] = cfg_reg;
        ADDR_W'(ADDR_CTRL):   rdata_next[0]   = tx_en_reg;
        ADDR_W'(ADDR_STAT):   rdata_next      = stat_word;
        ADDR_W'(ADDR_IRQEN):  rdata_next[3:0] = irq_en_reg;
        default:              raddrerr_next   = 1'b1;
      endcase
    end
  end

  // Set events are OR-ed in after the clear so they win over a same-cycle W1C
  always_comb begin
    sticky_set  = {wr_tx && tx_full, rx_valid && rx_full, rx_valid && rx_perr};
    sticky_w1c  = wr_stat ? bus.wdata[STAT_TX_OVF:STAT_PERR] : 3'b000;
    sticky_next = (sticky_reg & ~sticky_w1c) | sticky_set;

    cfg_next    = wr_cfg   ? cfg_t'(bus.wdata[4:0]) : cfg_reg;
    tx_en_next  = wr_ctrl  ? bus.wdata[0]           : tx_en_reg;
    irq_en_next = wr_irqen ? bus.wdata[3:0]         : irq_en_reg;

    irq_src                  = '0;
    irq_src[IRQ_RX_NONEMPTY] = !rx_empty;
    irq_src[IRQ_TX_EMPTY]    = tx_empty;
    irq_src[IRQ_PERR]        = sticky_reg[0];
    irq_src[IRQ_OVF]         = sticky_reg[1] | sticky_reg[2];
    irq_next = |(irq_en_reg & irq_src);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_reg      <= '0;
      tx_en_reg    <= 1'b0;
      irq_en_reg   <= '0;
      sticky_reg   <= '0;
      wack_reg     <= 1'b0;
      waddrerr_reg <= 1'b0;
      rack_reg     <= 1'b0;
      raddrerr_reg <= 1'b0;
      rdata_reg    <= '0;
      irq_reg      <= 1'b0;
    end else begin
      cfg_reg      <= cfg_next;
      tx_en_reg    <= tx_en_next;
      irq_en_reg   <= irq_en_next;
      sticky_reg   <= sticky_next;
      wack_reg     <= bus.wr_en;
      waddrerr_reg <= waddrerr_next;
      rack_reg     <= bus.rd_en;
      raddrerr_reg <= raddrerr_next;
      rdata_reg    <= rdata_next;
      irq_reg      <= irq_next;
    end
  end

  assign bus.wack     = wack_reg;
  assign bus.waddrerr = waddrerr_reg;
  assign bus.rack     = rack_reg;
  assign bus.raddrerr = raddrerr_reg;
  assign bus.rdata    = rdata_reg;

  assign cfg_data_bits = cfg_reg.data_bits;
  assign cfg_stop_bits = cfg_reg.stop;
  assign cfg_par_en    = cfg_reg.par_en;
  assign cfg_par_odd   = cfg_reg.par_odd;
  assign irq           = irq_reg;

endmodule
